// File: rtl/ssd1306_spi_rx_if.sv
// Port bundle for the SSD1306 SPI receiver: SPI pins in, framebuffer write port
// and exported display state out.
interface ssd1306_spi_rx_if;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_dc;
    logic        fb_we;
    logic [12:0] fb_waddr;
    logic [1:0]  fb_wdata;
    logic        invert;
    logic        disp_on;
    logic        overflow;

    modport master (
        output spi_sck, spi_mosi, spi_cs_n, spi_dc,
        input  fb_we, fb_waddr, fb_wdata, invert, disp_on, overflow
    );

    modport slave (
        input  spi_sck, spi_mosi, spi_cs_n, spi_dc,
        output fb_we, fb_waddr, fb_wdata, invert, disp_on, overflow
    );
endinterface

// File: rtl/ssd1306_spi_rx.sv
// SPI slave that decodes an SSD1306 command/data stream into per-pixel writes
// for the 128x64 scan-out framebuffer, with a horizontal-mode write pointer.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a pending byte; decodes commands, starts unpack
// UNPACK | eight cycles of one-pixel framebuffer writes for a data byte
// PARAM1 | next byte is the first parameter of a multi-byte command
// PARAM2 | next byte is the end value of a column/page window command
module ssd1306_spi_rx #(
    parameter int COLS  = 128,
    parameter int PAGES = 8
) (
    input logic             CLK25MHz,
    input logic             rst_n,
    ssd1306_spi_rx_if.slave bus
);
    localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
    localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);

    typedef enum logic [1:0] {IDLE, UNPACK, PARAM1, PARAM2} state_t;
    typedef enum logic [1:0] {PC_NONE, PC_COL, PC_PAGE} pcmd_t;

    logic [1:0]  sck_sync, mosi_sync, cs_sync, dc_sync;
    logic        sck_q, cs_q;
    logic        sck_rise, byte_done;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift;
    logic [7:0]  byte_new;

    logic        pend_valid, pend_dc, take;
    logic [7:0]  pend_byte;

    state_t      state, state_n;
    pcmd_t       pcmd;
    logic [7:0]  ubyte;
    logic [2:0]  k;
    logic [6:0]  col, col_start, col_end;
    logic [2:0]  page, page_start, page_end;
    logic        invert_r, disp_on_r, overflow_r;

    logic        fb_we_c;
    logic [12:0] fb_waddr_c;
    logic [1:0]  fb_wdata_c;

    function automatic logic takes_param(input logic [7:0] c);
        logic r;
        case (c)
            8'h20, 8'h21, 8'h22, 8'h81, 8'h8D, 8'hA8,
            8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    // CS idles high so a reset never looks like a selected bus.
    always_ff @(posedge CLK25MHz or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            cs_sync   <= 2'b11;
            dc_sync   <= 2'b00;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[0], bus.spi_sck};
            mosi_sync <= {mosi_sync[0], bus.spi_mosi};
            cs_sync   <= {cs_sync[0], bus.spi_cs_n};
            dc_sync   <= {dc_sync[0], bus.spi_dc};
            sck_q     <= sck_sync[1];
            cs_q      <= cs_sync[1];
        end
    end

    assign sck_rise  = sck_sync[1] & ~sck_q;
    assign byte_new  = {shift, mosi_sync[1]};
    // cs_q keeps a byte whose last edge coincides with the CS rise
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (!cs_sync[1] || !cs_q);
    assign take      = pend_valid && (state != UNPACK);

    always_ff @(posedge CLK25MHz or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
            shift   <= 7'd0;
        end else if (byte_done) begin
            bit_cnt <= 3'd0;
        end else if (cs_sync[1]) begin
            bit_cnt <= 3'd0;
        end else if (sck_rise) begin
            shift   <= byte_new[6:0];
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge CLK25MHz or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_dc    <= 1'b0;
            pend_byte  <= 8'd0;
            overflow_r <= 1'b0;
        end else begin
            if (byte_done && (!pend_valid || take)) begin
                pend_valid <= 1'b1;
                pend_dc    <= dc_sync[1];
                pend_byte  <= byte_new;
            end else if (take) begin
                pend_valid <= 1'b0;
            end
            if (byte_done && pend_valid && !take)
                overflow_r <= 1'b1;
        end
    end

    always_ff @(posedge CLK25MHz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        fb_we_c    = 1'b0;
        fb_waddr_c = 13'd0;
        fb_wdata_c = 2'b00;
        case (state)
            IDLE: begin
                if (take) begin
                    if (pend_dc)                 state_n = UNPACK;
                    else if (takes_param(pend_byte)) state_n = PARAM1;
                end
            end
            PARAM1: begin
                if (take) state_n = (pcmd == PC_NONE) ? IDLE : PARAM2;
            end
            PARAM2: begin
                if (take) state_n = IDLE;
            end
            UNPACK: begin
                fb_we_c    = 1'b1;
                fb_waddr_c = {page, col, k};
                fb_wdata_c = {1'b0, ubyte[k]};
                if (k == 3'd7) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK25MHz or negedge rst_n) begin
        if (!rst_n) begin
            pcmd       <= PC_NONE;
            ubyte      <= 8'd0;
            k          <= 3'd0;
            col        <= 7'd0;
            col_start  <= 7'd0;
            col_end    <= COL_LAST;
            page       <= 3'd0;
            page_start <= 3'd0;
            page_end   <= PAGE_LAST;
            invert_r   <= 1'b0;
            disp_on_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    if (pend_dc) begin
                        ubyte <= pend_byte;
                        k     <= 3'd0;
                    end else begin
                        casez (pend_byte)
                            8'hA6:        invert_r  <= 1'b0;
                            8'hA7:        invert_r  <= 1'b1;
                            8'hAE:        disp_on_r <= 1'b0;
                            8'hAF:        disp_on_r <= 1'b1;
                            8'b1011_0???: page      <= pend_byte[2:0];
                            8'b0000_????: col[3:0]  <= pend_byte[3:0];
                            8'b0001_0???: col[6:4]  <= pend_byte[2:0];
                            8'h21:        pcmd      <= PC_COL;
                            8'h22:        pcmd      <= PC_PAGE;
                            default:      if (takes_param(pend_byte)) pcmd <= PC_NONE;
                        endcase
                    end
                end
                PARAM1: if (take) begin
                    if (pcmd == PC_COL) begin
                        col_start <= pend_byte[6:0];
                        col       <= pend_byte[6:0];
                    end else if (pcmd == PC_PAGE) begin
                        page_start <= pend_byte[2:0];
                        page       <= pend_byte[2:0];
                    end
                end
                PARAM2: if (take) begin
                    if (pcmd == PC_COL)       col_end  <= pend_byte[6:0];
                    else if (pcmd == PC_PAGE) page_end <= pend_byte[2:0];
                end
                UNPACK: begin
                    k <= k + 3'd1;
                    if (k == 3'd7) begin
                        if (col == col_end) begin
                            col  <= col_start;
                            page <= (page == page_end) ? page_start : page + 3'd1;
                        end else begin
                            col <= col + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fb_we    = fb_we_c;
    assign bus.fb_waddr = fb_waddr_c;
    assign bus.fb_wdata = fb_wdata_c;
    assign bus.invert   = invert_r;
    assign bus.disp_on  = disp_on_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Directed bench for ssd1306_spi_rx: SPI byte stimulus, captured pixel writes
// compared against bursts built from the {page, col, bit} address formula.
module tb_ssd1306_spi_rx;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [14:0] wq[$];

    ssd1306_spi_rx_if bus();

    ssd1306_spi_rx #(.COLS(128), .PAGES(8)) dut (
        .CLK25MHz(clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #20 clk = ~clk;

    always @(negedge clk)
        if (rst_n && bus.fb_we) wq.push_back({bus.fb_waddr, bus.fb_wdata});

    function automatic logic [119:0] exp_burst(input logic [2:0] pg, input logic [6:0] cl,
                                               input logic [7:0] b);
        logic [119:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*15 +: 15] = {pg, cl, 3'(i), 1'b0, b[i]};
        return v;
    endfunction

    task automatic get_burst(output logic [119:0] v);
        int t;
        t = 0;
        v = 'x;
        while (wq.size() < 8 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (wq.size() >= 8)
            for (int i = 0; i < 8; i++) v[i*15 +: 15] = wq.pop_front();
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int n, input bit cs_end);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            bus.spi_mosi = b[i];
            bus.spi_dc   = dc;
            repeat (2) @(negedge clk);
            bus.spi_sck = 1'b1;
            if (cs_end && i == 0) bus.spi_cs_n = 1'b1;
            repeat (2) @(negedge clk);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, dc, 8, 1'b0);
    endtask

    task automatic select();
        bus.spi_cs_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_dc   = 1'b0;
        bus.spi_cs_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        wq.delete();
    endtask

    task automatic test_reset();
        logic [119:0] obs;
        logic [17:0]  outs;
        int t;
        do_reset();
        outs = {bus.fb_we, bus.fb_waddr, bus.fb_wdata, bus.invert, bus.disp_on, bus.overflow};
        n_cmp++;
        if (outs !== 18'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected %h", outs, 18'd0);
        end
        select();
        send_byte(8'hA7, 1'b0);
        send_byte(8'hB5, 1'b0);
        send_byte(8'h3C, 1'b1);
        t = 0;
        while (bus.fb_we !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (bus.fb_we !== 1'b1 || bus.invert !== 1'b1) begin
            n_err++; $display("FAIL reset_pre_burst: got we=%b inv=%b expected we=1 inv=1", bus.fb_we, bus.invert);
        end
        repeat (2) @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.fb_we !== 1'b0) begin
            n_err++; $display("FAIL reset_async_we: got %b expected 0", bus.fb_we);
        end
        bus.spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        outs = {bus.fb_we, bus.fb_waddr, bus.fb_wdata, bus.invert, bus.disp_on, bus.overflow};
        n_cmp++;
        if (outs !== 18'd0) begin
            n_err++; $display("FAIL reset_release_outputs: got %h expected %h", outs, 18'd0);
        end
        wq.delete();
        select();
        send_byte(8'h81, 1'b1);
        get_burst(obs);
        n_cmp++;
        if (obs !== exp_burst(3'd0, 7'd0, 8'h81)) begin
            n_err++; $display("FAIL reset_first_burst: got %h expected %h", obs, exp_burst(3'd0, 7'd0, 8'h81));
        end
    endtask

    task automatic test_data();
        logic [119:0] obs;
        logic [15:0]  wr;
        do_reset();
        select();
        send_byte(8'hA5, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (bus.fb_we !== 1'b0) begin
            n_err++; $display("FAIL data_we_early: got %b expected 0", bus.fb_we);
        end
        @(negedge clk);
        wr = {bus.fb_we, bus.fb_waddr, bus.fb_wdata};
        n_cmp++;
        if (wr !== {1'b1, 13'd0, 2'b01}) begin
            n_err++; $display("FAIL data_first_write: got %h expected %h", wr, {1'b1, 13'd0, 2'b01});
        end
        get_burst(obs);
        n_cmp++;
        if (obs !== exp_burst(3'd0, 7'd0, 8'hA5)) begin
            n_err++; $display("FAIL data_a5: got %h expected %h", obs, exp_burst(3'd0, 7'd0, 8'hA5));
        end
        send_byte(8'h3C, 1'b1);
        get_burst(obs);
        n_cmp++;
        if (obs !== exp_burst(3'd0, 7'd1, 8'h3C)) begin
            n_err++; $display("FAIL data_next_col: got %h expected %h", obs, exp_burst(3'd0, 7'd1, 8'h3C));
        end
    endtask

    task automatic test_commands();
        logic [119:0] obs;
        do_reset();
        select();
        send_byte(8'hB3, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'hFF, 1'b1);
        get_burst(obs);
        n_cmp++;
        if (obs !== exp_burst(3'd3, 7'h25, 8'hFF)) begin
            n_err++; $display("FAIL cmd_pointer: got %h expected %h", obs, exp_burst(3'd3, 7'h25, 8'hFF));
        end
    endtask

    task automatic test_window();
        logic [119:0] obs;
        logic [7:0]   db [5];
        logic [2:0]   pg [5];
        logic [6:0]   cl [5];
        db = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        pg = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd6};
        cl = '{7'd126, 7'd127, 7'd126, 7'd127, 7'd126};
        do_reset();
        select();
        send_byte(8'h21, 1'b0);
        send_byte(8'h7E, 1'b0);
        send_byte(8'h7F, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h07, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_byte(db[i], 1'b1);
            get_burst(obs);
            n_cmp++;
            if (obs !== exp_burst(pg[i], cl[i], db[i])) begin
                n_err++; $display("FAIL window_byte%0d: got %h expected %h", i, obs, exp_burst(pg[i], cl[i], db[i]));
            end
        end
    endtask

    task automatic test_mode();
        logic [119:0] obs;
        do_reset();
        select();
        send_byte(8'hA7, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (bus.invert !== 1'b0) begin
            n_err++; $display("FAIL mode_invert_early: got %b expected 0", bus.invert);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.invert !== 1'b1) begin
            n_err++; $display("FAIL mode_invert_set: got %b expected 1", bus.invert);
        end
        send_byte(8'hAF, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.disp_on !== 1'b1) begin
            n_err++; $display("FAIL mode_disp_on: got %b expected 1", bus.disp_on);
        end
        send_byte(8'h81, 1'b0);
        send_byte(8'hA6, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.invert !== 1'b1) begin
            n_err++; $display("FAIL mode_contrast_param: got %b expected 1", bus.invert);
        end
        send_byte(8'hA6, 1'b0);
        send_byte(8'hAE, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.invert, bus.disp_on} !== 2'b00) begin
            n_err++; $display("FAIL mode_clear: got %b expected 00", {bus.invert, bus.disp_on});
        end
        send_byte(8'h0F, 1'b1);
        get_burst(obs);
        n_cmp++;
        if (obs !== exp_burst(3'd0, 7'd0, 8'h0F)) begin
            n_err++; $display("FAIL mode_pointer_kept: got %h expected %h", obs, exp_burst(3'd0, 7'd0, 8'h0F));
        end
    endtask

    task automatic test_abort();
        logic [119:0] obs;
        do_reset();
        select();
        send_bits(8'hFF, 1'b1, 5, 1'b0);
        bus.spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        select();
        send_byte(8'h01, 1'b1);
        get_burst(obs);
        n_cmp++;
        if (obs !== exp_burst(3'd0, 7'd0, 8'h01)) begin
            n_err++; $display("FAIL abort_burst: got %h expected %h", obs, exp_burst(3'd0, 7'd0, 8'h01));
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (wq.size() !== 0) begin
            n_err++; $display("FAIL abort_single_burst: got %0d extra writes expected 0", wq.size());
        end
        select();
        send_bits(8'h80, 1'b1, 8, 1'b1);
        get_burst(obs);
        n_cmp++;
        if (obs !== exp_burst(3'd0, 7'd1, 8'h80)) begin
            n_err++; $display("FAIL abort_cs_same_edge: got %h expected %h", obs, exp_burst(3'd0, 7'd1, 8'h80));
        end
    endtask

    task automatic test_overflow();
        do_reset();
        select();
        send_byte(8'h01, 1'b1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bus.overflow !== 1'b0) begin
            n_err++; $display("FAIL overflow_clear: got %b expected 0", bus.overflow);
        end
        bus.spi_mosi = 1'b1;
        bus.spi_dc   = 1'b1;
        repeat (3) @(negedge clk);
        force dut.sck_rise = 1'b1;
        repeat (120) @(negedge clk);
        release dut.sck_rise;
        bus.spi_cs_n = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (bus.overflow !== 1'b1) begin
            n_err++; $display("FAIL overflow_set: got %b expected 1", bus.overflow);
        end
        select();
        send_byte(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bus.overflow !== 1'b1) begin
            n_err++; $display("FAIL overflow_sticky: got %b expected 1", bus.overflow);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_dc   = 1'b0;
        test_reset();
        test_data();
        test_commands();
        test_window();
        test_mode();
        test_abort();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
